mem_arbiter: RTL and testbench

- Parametrised multi-port line memory shared by NUM_PORTS requestors. Typical ports: I-cache refill, D-cache refill, D-cache write-back.
- Generalises the fixed two-client unified memory: configurable port count, line width, depth and access latency.
- Adds round-robin arbitration, per-port completion pulses and out-of-range protection.
- Sits between the cache line interfaces and the backing storage in the cpu top level.

---
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: line memory shared by NUM_PORTS requestors through a round-robin arbiter.
//
// One transaction runs at a time. The winning port's we/addr/wline are captured at grant.
// The access happens LATENCY-1 cycles after the grant edge. The port's valid bit pulses
// in the following cycle.
//
// Ports:
//   clk       clock, all state on rising edge
//   rst       asynchronous active-low reset
//   req       per-port request, held until that port's valid pulse
//   we        per-port write select (1 = write line, 0 = read line)
//   addr      packed line indices, port p at [p*ADDR_BITS +: ADDR_BITS]
//   wline     packed write lines, port p at [p*LINE_BITS +: LINE_BITS]
//   rline     registered read data, shared by all ports, valid in the valid cycle
//   valid     one-hot completion pulse for the granted port
//   busy      high while a transaction is in flight
//   grant_id  index of the current or last granted port
module mem_arbiter #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 3
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [NUM_PORTS-1:0]                                req,
  input  logic [NUM_PORTS-1:0]                                we,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]                      addr,
  input  logic [NUM_PORTS*LINE_BITS-1:0]                      wline,
  output logic [LINE_BITS-1:0]                                rline,
  output logic [NUM_PORTS-1:0]                                valid,
  output logic                                                busy,
  output logic [(NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1)-1:0] grant_id
);

  localparam int unsigned GidW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [GidW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [GidW-1:0]        gid_q, gid_d;
  logic                   we_q, we_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [LINE_BITS-1:0]   wline_q, wline_d;
  logic [LINE_BITS-1:0]   rline_q;

  logic [LINE_BITS-1:0]   mem [DEPTH];

  // Arbitration result
  logic                   gnt_found;
  logic [GidW-1:0]        gnt_idx;
  logic                   sel_we;
  logic [ADDR_BITS-1:0]   sel_addr;
  logic [LINE_BITS-1:0]   sel_wline;

  // Access performed on the coming edge
  logic                   do_access;
  logic                   acc_we;
  logic [ADDR_BITS-1:0]   acc_addr;
  logic [LINE_BITS-1:0]   acc_wline;
  logic                   in_range;
  logic [IdxW-1:0]        mem_idx;
  logic                   mem_wr;

  // Scan upward from rr_ptr with an explicit wrap so non-power-of-two port counts work.
  always_comb begin
    int unsigned cand;
    logic [GidW-1:0] cand_idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      cand_idx = GidW'(cand);
      if (!gnt_found && req[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wline = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (gnt_idx == GidW'(p)) begin
        sel_we    = we[p];
        sel_addr  = addr[p*ADDR_BITS +: ADDR_BITS];
        sel_wline = wline[p*LINE_BITS +: LINE_BITS];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    gid_d     = gid_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wline_d   = wline_q;
    do_access = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wline = wline_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          gid_d   = gnt_idx;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wline_d = sel_wline;
          cnt_d   = CntW'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = StWait;
          end else begin
            // Single-cycle latency: access straight from the port on the grant edge.
            state_d   = StResp;
            do_access = 1'b1;
            acc_we    = sel_we;
            acc_addr  = sel_addr;
            acc_wline = sel_wline;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d   = StResp;
          do_access = 1'b1;
        end
      end
      StResp: begin
        state_d  = StIdle;
        rr_ptr_d = (gid_q == GidW'(NUM_PORTS - 1)) ? '0 : gid_q + GidW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Compare in ADDR_BITS+1 bits so DEPTH == 2**ADDR_BITS does not truncate to zero.
  always_comb begin
    in_range = ({1'b0, acc_addr} < (ADDR_BITS + 1)'(DEPTH));
    mem_idx  = acc_addr[IdxW-1:0];
    // Gated by rst so a LATENCY==1 grant cannot write while reset is held.
    mem_wr   = do_access && acc_we && in_range && rst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wline_q  <= '0;
      rline_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wline_q  <= wline_d;
      if (do_access && !acc_we) begin
        rline_q <= in_range ? mem[mem_idx] : '0;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_idx] <= acc_wline;
    end
  end

  always_comb begin
    busy  = (state_q != StIdle);
    valid = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      valid[p] = (state_q == StResp) && (gid_q == GidW'(p));
    end
  end

  assign rline    = rline_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  // Instance A: 3 ports, latency 3, 16 lines.  Instance B: 5 ports, latency 1, 16 lines.
  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [2:0]   req_a = '0, we_a = '0;
  logic [29:0]  addr_a = '0;
  logic [383:0] wline_a = '0;
  logic [127:0] rline_a;
  logic [2:0]   valid_a;
  logic         busy_a;
  logic [1:0]   gid_a;

  logic [4:0]   req_b = '0, we_b = '0;
  logic [49:0]  addr_b = '0;
  logic [639:0] wline_b = '0;
  logic [127:0] rline_b;
  logic [4:0]   valid_b;
  logic         busy_b;
  logic [2:0]   gid_b;

  mem_arbiter #(.NUM_PORTS(3), .LINE_BITS(128), .ADDR_BITS(10), .DEPTH(16), .LATENCY(3)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wline(wline_a),
    .rline(rline_a), .valid(valid_a), .busy(busy_a), .grant_id(gid_a)
  );

  mem_arbiter #(.NUM_PORTS(5), .LINE_BITS(128), .ADDR_BITS(10), .DEPTH(16), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wline(wline_b),
    .rline(rline_b), .valid(valid_b), .busy(busy_b), .grant_id(gid_b)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 = idle, otherwise cycles elapsed since grant; phase == latency is the valid cycle.
  int           cfg_n[2] = '{3, 5};
  int           cfg_l[2] = '{3, 1};
  int           cfg_d[2] = '{16, 16};
  int           m_phase[2] = '{0, 0};
  int           m_gport[2] = '{0, 0};
  int           m_rr[2]    = '{0, 0};
  logic         m_gwe[2];
  logic [9:0]   m_gaddr[2];
  logic [127:0] m_gwl[2];
  logic [127:0] m_rline[2] = '{128'h0, 128'h0};
  bit           m_rknown[2] = '{1'b1, 1'b1};
  logic [127:0] mm0 [int];
  logic [127:0] mm1 [int];

  task automatic model_access(input int k);
    int a;
    a = int'(m_gaddr[k]);
    if (m_gwe[k]) begin
      if (a < cfg_d[k]) begin
        if (k == 0) mm0[a] = m_gwl[k];
        else        mm1[a] = m_gwl[k];
      end
    end else if (a >= cfg_d[k]) begin
      m_rline[k]  = '0;
      m_rknown[k] = 1'b1;
    end else if (k == 0) begin
      m_rknown[0] = mm0.exists(a);
      if (m_rknown[0]) m_rline[0] = mm0[a];
    end else begin
      m_rknown[1] = mm1.exists(a);
      if (m_rknown[1]) m_rline[1] = mm1[a];
    end
  endtask

  task automatic model_edge(input int k, input logic [4:0] rq, input logic [4:0] w,
                            input logic [49:0] ad, input logic [639:0] wl);
    bit found;
    int p, c;
    if (m_phase[k] == 0) begin
      found = 1'b0;
      p = 0;
      for (int i = 0; i < cfg_n[k]; i++) begin
        c = (m_rr[k] + i) % cfg_n[k];
        if (!found && rq[c]) begin
          found = 1'b1;
          p = c;
        end
      end
      if (found) begin
        m_gport[k] = p;
        m_gwe[k]   = w[p];
        m_gaddr[k] = ad[p*10 +: 10];
        m_gwl[k]   = wl[p*128 +: 128];
        m_phase[k] = 1;
        if (m_phase[k] == cfg_l[k]) model_access(k);
      end
    end else if (m_phase[k] < cfg_l[k]) begin
      m_phase[k]++;
      if (m_phase[k] == cfg_l[k]) model_access(k);
    end else begin
      m_rr[k]    = (m_gport[k] + 1) % cfg_n[k];
      m_phase[k] = 0;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_phase[k]  = 0;
        m_gport[k]  = 0;
        m_rr[k]     = 0;
        m_rline[k]  = '0;
        m_rknown[k] = 1'b1;
      end
    end else begin
      model_edge(0, {2'b00, req_a}, {2'b00, we_a}, {20'b0, addr_a}, {256'b0, wline_a});
      model_edge(1, req_b, we_b, addr_b, wline_b);
    end
  end

  function automatic logic [4:0] exp_valid(input int k);
    logic [4:0] v;
    v = '0;
    if (m_phase[k] == cfg_l[k]) v[m_gport[k]] = 1'b1;
    return v;
  endfunction

  // Outputs only move on posedge or reset, so the negedge sees settled values.
  always @(negedge clk) begin
    chk("a_busy", 128'(busy_a), 128'(m_phase[0] != 0));
    chk("a_valid", 128'({2'b00, valid_a}), 128'(exp_valid(0)));
    chk("a_grant_id", 128'(gid_a), 128'(m_gport[0]));
    if (m_rknown[0]) chk("a_rline", rline_a, m_rline[0]);
    chk("b_busy", 128'(busy_b), 128'(m_phase[1] != 0));
    chk("b_valid", 128'(valid_b), 128'(exp_valid(1)));
    chk("b_grant_id", 128'(gid_b), 128'(m_gport[1]));
    if (m_rknown[1]) chk("b_rline", rline_b, m_rline[1]);
  end

  // ---------------- directed stimulus ----------------
  // Issue one request at a negedge and return at the negedge of its valid cycle.
  task automatic txn(input int k, input int p, input logic w, input logic [9:0] ad,
                     input logic [127:0] wl, output int lat, output logic [127:0] rl);
    logic got;
    if (k == 0) begin
      req_a[p] = 1'b1; we_a[p] = w; addr_a[p*10 +: 10] = ad; wline_a[p*128 +: 128] = wl;
    end else begin
      req_b[p] = 1'b1; we_b[p] = w; addr_b[p*10 +: 10] = ad; wline_b[p*128 +: 128] = wl;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = (k == 0) ? valid_a[p] : valid_b[p];
    end
    if (!got) chk("txn_timeout", 128'(got), 128'(1));
    rl = (k == 0) ? rline_a : rline_b;
    if (k == 0) req_a[p] = 1'b0;
    else        req_b[p] = 1'b0;
  endtask

  task automatic wait_pulse(input int k, output int port, output int at);
    logic [4:0] v;
    int n;
    port = -1;
    at   = 0;
    n    = 0;
    while (port < 0 && n < 30) begin
      @(negedge clk);
      n++;
      v = (k == 0) ? {2'b00, valid_a} : valid_b;
      for (int i = 0; i < 5; i++) if (v[i]) port = i;
    end
    at = cyc;
    if (port < 0) chk("pulse_timeout", 128'(0), 128'(1));
  endtask

  localparam logic [127:0] PatA5 = {16{8'hA5}};

  initial begin
    int lat, port, at, prev;
    logic [127:0] rl;

    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(busy_a), 128'(0));
    chk("reset_valid", 128'(valid_a), 128'(0));
    chk("reset_rline", rline_a, 128'h0);
    chk("reset_grant_id", 128'(gid_b), 128'(0));
    #1 rst = 1'b1;
    @(negedge clk);

    // Single read of a preloaded line through port 1.
    txn(0, 0, 1'b1, 10'd5, PatA5, lat, rl);
    @(negedge clk);
    txn(0, 1, 1'b0, 10'd5, '0, lat, rl);
    chk("rd5_latency", 128'(lat), 128'(3));
    chk("rd5_rline", rl, PatA5);
    chk("rd5_valid", 128'(valid_a), 128'(3'b010));
    chk("rd5_grant_id", 128'(gid_a), 128'(1));
    @(negedge clk);

    // Write then read the same line; re-request lands during the valid cycle.
    txn(0, 2, 1'b1, 10'd7, 128'h1234, lat, rl);
    txn(0, 0, 1'b0, 10'd7, '0, lat, rl);
    chk("wr_rd_gap", 128'(lat), 128'(4));
    chk("wr_rd_rline", rl, 128'h1234);
    @(negedge clk);

    // Out of range on a 16-line memory: 20 must not alias line 4.
    txn(0, 0, 1'b1, 10'd4, 128'h4444, lat, rl);
    @(negedge clk);
    txn(0, 0, 1'b1, 10'd20, 128'hFF, lat, rl);
    chk("oor_wr_latency", 128'(lat), 128'(3));
    @(negedge clk);
    txn(0, 0, 1'b0, 10'd20, '0, lat, rl);
    chk("oor_rd_rline", rl, 128'h0);
    @(negedge clk);
    txn(0, 0, 1'b0, 10'd4, '0, lat, rl);
    chk("oor_line4_kept", rl, 128'h4444);
    @(negedge clk);

    // Contention from reset: all ports hold req.
    #1 rst = 1'b0;
    req_a = 3'b111; we_a = '0; addr_a = {10'd5, 10'd5, 10'd5};
    @(negedge clk);
    #1 rst = 1'b1;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      wait_pulse(0, port, at);
      chk("rr_order", 128'(port), 128'(i % 3));
      if (i > 0) chk("rr_gap", 128'(at - prev), 128'(4));
      if (i == 0) chk("rr_rline", rline_a, PatA5);
      prev = at;
    end
    req_a = 3'b101;
    wait_pulse(0, port, at);
    chk("rr_after_p2", 128'(port), 128'(0));
    req_a = '0;
    @(negedge clk);

    // Reset during the wait of a write: line 3 keeps the old value, pointer restarts at 0.
    txn(0, 0, 1'b1, 10'd3, 128'h3333, lat, rl);
    @(negedge clk);
    req_a = 3'b010; we_a[1] = 1'b1; addr_a[19:10] = 10'd3; wline_a[255:128] = 128'hDEAD;
    @(negedge clk);
    chk("abort_busy_before", 128'(busy_a), 128'(1));
    #1 rst = 1'b0;
    req_a = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_busy_after", 128'(busy_a), 128'(0));
    req_a = 3'b111; we_a = '0; addr_a = {10'd3, 10'd3, 10'd3};
    wait_pulse(0, port, at);
    chk("abort_first_grant", 128'(port), 128'(0));
    chk("abort_line3", rline_a, 128'h3333);
    req_a = '0;
    @(negedge clk);

    // Latency 1, five ports.
    txn(1, 3, 1'b1, 10'd9, 128'h99, lat, rl);
    @(negedge clk);
    txn(1, 4, 1'b0, 10'd9, '0, lat, rl);
    chk("b_rd_latency", 128'(lat), 128'(1));
    chk("b_rd_rline", rl, 128'h99);
    @(negedge clk);
    req_b = 5'b11000; we_b = '0; addr_b = {5{10'd9}};
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_pulse(1, port, at);
      chk("b_order", 128'(port), 128'((i % 2 == 0) ? 3 : 4));
      if (i > 0) chk("b_gap", 128'(at - prev), 128'(2));
      prev = at;
    end
    req_b = 5'b01001;
    wait_pulse(1, port, at);
    chk("b_wrap", 128'(port), 128'(0));
    req_b = '0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
